// File: rtl/fir_ops_pkg.sv
// fir_ops_pkg: op codes and constants shared by the FIR controller and datapath
package fir_ops_pkg;
  localparam int DATA_W = 16;
  localparam logic [3:0] REG_ZERO = 4'hF;
  localparam logic [3:0] REG_OUT = 4'h0;
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    COPY  = 3'd1,
    LOAD1 = 3'd2,
    LOAD2 = 3'd3,
    ADD   = 3'd4,
    SUB   = 3'd5,
    MUL   = 3'd6
  } alu_op_t;
endpackage

// File: rtl/rf16x16.sv
// rf16x16: 16x16 register file, two async reads, one sync write, R15 reads as zero
module rf16x16
  import fir_ops_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr1,
  input  logic [3:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] r0
);
  // Only R0..R14 are stored; R15 is a constant zero.
  logic [DATA_W-1:0] regs [15];
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs[raddr2];
  assign r0 = regs[REG_OUT];
endmodule

// File: rtl/fir_datapath.sv
// fir_datapath: executes controller register-transfer commands with a signed ALU
module fir_datapath
  import fir_ops_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] ext_data1,
  input  logic [DATA_W-1:0] ext_data2,
  output logic [DATA_W-1:0] outreg_data,
  output logic              overflow
);
  logic [DATA_W-1:0] a, b, wdata;
  logic [DATA_W:0] sum, diff;
  logic signed [2*DATA_W-1:0] prod;
  logic we;
  rf16x16 u_rf (
    .clk(clk), .n_rst(n_rst), .we(we), .waddr(dest), .wdata(wdata),
    .raddr1(src1), .raddr2(src2), .rdata1(a), .rdata2(b), .r0(outreg_data)
  );
  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
  assign prod = $signed(a) * $signed(b);
  // Results always wrap to 16 bits; overflow only flags, never blocks the write.
  always_comb begin
    we = 1'b0;
    wdata = '0;
    overflow = 1'b0;
    case (op)
      COPY:  begin we = 1'b1; wdata = a; end
      LOAD1: begin we = 1'b1; wdata = ext_data1; end
      LOAD2: begin we = 1'b1; wdata = ext_data2; end
      ADD:   begin we = 1'b1; wdata = sum[DATA_W-1:0]; overflow = sum[DATA_W] ^ sum[DATA_W-1]; end
      SUB:   begin we = 1'b1; wdata = diff[DATA_W-1:0]; overflow = diff[DATA_W] ^ diff[DATA_W-1]; end
      MUL:   begin
        we = 1'b1;
        wdata = prod[DATA_W-1:0];
        overflow = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_datapath.sv
// tb_fir_datapath: directed checks of register transfers, overflow and reset
module tb_fir_datapath;
  import fir_ops_pkg::*;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] src1 = '0, src2 = '0, dest = '0;
  logic [15:0] ext_data1 = '0, ext_data2 = '0;
  logic [15:0] outreg_data;
  logic overflow;
  int checks = 0;
  int errors = 0;

  fir_datapath dut (
    .clk(clk), .n_rst(n_rst), .op(op), .src1(src1), .src2(src2), .dest(dest),
    .ext_data1(ext_data1), .ext_data2(ext_data2),
    .outreg_data(outreg_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
    op = o; src1 = s1; src2 = s2; dest = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [3:0] r);
    cmd(COPY, r, 4'd0, 4'd0);
    tick();
  endtask

  initial begin
    #12 n_rst = 1'b1;
    chk("rst_out", outreg_data, 16'h0000);
    chk("rst_ovf", {15'd0, overflow}, 16'h0000);
    tick();
    ext_data1 = 16'h1234; cmd(LOAD1, 0, 0, 3); tick();
    show(3);
    chk("r3_loaded", outreg_data, 16'h1234);
    #2 n_rst = 1'b0;
    #1 chk("async_rst_out", outreg_data, 16'h0000);
    n_rst = 1'b1;
    show(3);
    chk("r3_cleared", outreg_data, 16'h0000);

    ext_data1 = 16'h0005; cmd(LOAD1, 0, 0, 1);
    chk("load1_ovf", {15'd0, overflow}, 16'h0000); tick();
    ext_data2 = 16'h0003; cmd(LOAD2, 0, 0, 5);
    chk("load2_ovf", {15'd0, overflow}, 16'h0000); tick();
    cmd(MUL, 1, 5, 10);
    chk("mul_small_ovf", {15'd0, overflow}, 16'h0000); tick();
    show(10);
    chk("mul_small", outreg_data, 16'h000F);

    ext_data1 = 16'h7FFF; cmd(LOAD1, 0, 0, 1); tick();
    ext_data1 = 16'h0001; cmd(LOAD1, 0, 0, 2); tick();
    cmd(ADD, 1, 2, 9);
    chk("add_ovf", {15'd0, overflow}, 16'h0001); tick();
    show(9);
    chk("add_wrap", outreg_data, 16'h8000);
    cmd(SUB, 9, 2, 9);
    chk("sub_ovf", {15'd0, overflow}, 16'h0001); tick();
    show(9);
    chk("sub_wrap", outreg_data, 16'h7FFF);

    ext_data1 = 16'h0100; cmd(LOAD1, 0, 0, 1); tick();
    cmd(LOAD1, 0, 0, 2); tick();
    cmd(MUL, 1, 2, 10);
    chk("mul_big_ovf", {15'd0, overflow}, 16'h0001); tick();
    show(10);
    chk("mul_big", outreg_data, 16'h0000);
    ext_data1 = 16'hFFFF; cmd(LOAD1, 0, 0, 1); tick();
    cmd(LOAD1, 0, 0, 2); tick();
    cmd(MUL, 1, 2, 10);
    chk("mul_neg_ovf", {15'd0, overflow}, 16'h0000); tick();
    show(10);
    chk("mul_neg", outreg_data, 16'h0001);

    ext_data1 = 16'hABCD; cmd(LOAD1, 0, 0, 15); tick();
    show(15);
    chk("r15_zero", outreg_data, 16'h0000);
    cmd(COPY, 15, 0, 9); tick();
    cmd(ADD, 9, 10, 0);
    chk("add_small_ovf", {15'd0, overflow}, 16'h0000); tick();
    chk("copy_r15", outreg_data, 16'h0001);

    ext_data1 = 16'h0002; cmd(LOAD1, 0, 0, 9); tick();
    cmd(ADD, 9, 9, 9); tick();
    show(9);
    chk("self_add1", outreg_data, 16'h0004);
    cmd(ADD, 9, 9, 9); tick();
    cmd(COPY, 9, 0, 0);
    chk("out_pre_edge", outreg_data, 16'h0004);
    tick();
    chk("self_add2", outreg_data, 16'h0008);

    ext_data1 = 16'h7FFF; cmd(LOAD1, 0, 0, 1); tick();
    cmd(3'b111, 1, 1, 0);
    chk("rsvd_ovf", {15'd0, overflow}, 16'h0000); tick();
    chk("rsvd_nowrite", outreg_data, 16'h0008);
    cmd(NOP, 1, 1, 0);
    chk("nop_ovf", {15'd0, overflow}, 16'h0000); tick();
    chk("nop_nowrite", outreg_data, 16'h0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
